// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON permutation engine.
// The serial S-box datapath is selected with the ASCON_SERIAL_SBOX_EN macro.
package ascon_pkg;

  // Default number of S-box columns handled per SUB cycle in serial mode
  localparam int unsigned SLICE_DEF = 8;

  typedef logic [63:0]  word_t;
  typedef logic [319:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONST = 2'd1,
    ST_SUB   = 2'd2,
    ST_LIN   = 2'd3
  } fsm_t;

  // Rotation pairs (a, b) of the linear diffusion layer, one pair per word
  localparam int unsigned ROT_X0_A = 19;
  localparam int unsigned ROT_X0_B = 28;
  localparam int unsigned ROT_X1_A = 61;
  localparam int unsigned ROT_X1_B = 39;
  localparam int unsigned ROT_X2_A = 1;
  localparam int unsigned ROT_X2_B = 6;
  localparam int unsigned ROT_X3_A = 10;
  localparam int unsigned ROT_X3_B = 17;
  localparam int unsigned ROT_X4_A = 7;
  localparam int unsigned ROT_X4_B = 41;

  // Round constant XORed into the low byte of x2: 0xF0 for r=0 down to 0x4B for r=11
  function automatic logic [7:0] rc(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

endpackage

// File: rtl/ascon_linear_layer.sv
// Combinational ASCON linear diffusion: xi ^= ror(xi,a) ^ ror(xi,b) for all five words.
module ascon_linear_layer
  import ascon_pkg::*;
(
  input  logic [319:0] i_state,
  output logic [319:0] o_state
);

  function automatic word_t ror64(input word_t x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  word_t w_x0, w_x1, w_x2, w_x3, w_x4;

  assign {w_x0, w_x1, w_x2, w_x3, w_x4} = i_state;

  assign o_state = {
    w_x0 ^ ror64(w_x0, ROT_X0_A) ^ ror64(w_x0, ROT_X0_B),
    w_x1 ^ ror64(w_x1, ROT_X1_A) ^ ror64(w_x1, ROT_X1_B),
    w_x2 ^ ror64(w_x2, ROT_X2_A) ^ ror64(w_x2, ROT_X2_B),
    w_x3 ^ ror64(w_x3, ROT_X3_A) ^ ror64(w_x3, ROT_X3_B),
    w_x4 ^ ror64(w_x4, ROT_X4_A) ^ ror64(w_x4, ROT_X4_B)
  };

endmodule

// File: rtl/ascon_sbox.sv
// 5-bit ASCON S-box, column bit 4 = x0 ... bit 0 = x4.
module ascon_sbox (
  input  logic [4:0] i_x,
  output logic [4:0] o_y
);

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  assign o_y = SBOX[i_x];

endmodule

// File: rtl/ascon_permutation.sv
// Iterative ASCON permutation, 1..12 rounds over a 320-bit state.
// Default build: one full round per cycle (64 S-boxes).
// With ASCON_SERIAL_SBOX_EN defined: CONST / SUB (64/SLICE cycles) / LIN per round.
// In both modes done, ready and state_out are registered and appear in the last
// cycle of the run, so a start accepted in that cycle chains with no bubble.
module ascon_permutation
  import ascon_pkg::*;
#(
  parameter int unsigned SLICE = SLICE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   rounds,
  input  logic [319:0] state_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [319:0] state_out
);

  if ((SLICE == 0) || ((64 % SLICE) != 0)) begin : g_bad_slice
    $error("SLICE must divide 64");
  end

  fsm_t         r_fsm;
  logic [3:0]   r_round;
  state_t       r_state;
  state_t       r_state_out;
  logic         r_ready;
  logic         r_busy;
  logic         r_done;
  logic         w_accept;

  assign w_accept  = start && r_ready && (rounds != 4'd0) && (rounds <= 4'd12);
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign state_out = r_state_out;

`ifdef ASCON_SERIAL_SBOX_EN

  localparam int unsigned NCOL = 64 / SLICE;
  localparam int unsigned CW   = (NCOL > 1) ? $clog2(NCOL) : 1;

  logic [CW-1:0] r_col;
  logic [5:0]    w_base;
  logic [4:0]    w_col_in  [SLICE];
  logic [4:0]    w_col_out [SLICE];
  state_t        w_sub_next;
  state_t        w_lin_in;
  state_t        w_lin_out;

  // Gather the current slice of columns and scatter the substituted bits back
  always_comb begin
    w_base     = 6'(int'(r_col) * SLICE);
    w_sub_next = r_state;
    for (int i = 0; i < int'(SLICE); i++) begin
      w_col_in[i] = {r_state[256 + int'(w_base) + i], r_state[192 + int'(w_base) + i],
                     r_state[128 + int'(w_base) + i], r_state[64 + int'(w_base) + i],
                     r_state[int'(w_base) + i]};
      w_sub_next[256 + int'(w_base) + i] = w_col_out[i][4];
      w_sub_next[192 + int'(w_base) + i] = w_col_out[i][3];
      w_sub_next[128 + int'(w_base) + i] = w_col_out[i][2];
      w_sub_next[64 + int'(w_base) + i]  = w_col_out[i][1];
      w_sub_next[int'(w_base) + i]       = w_col_out[i][0];
    end
  end

  for (genvar g = 0; g < int'(SLICE); g++) begin : g_sbox
    ascon_sbox u_sbox (
      .i_x (w_col_in[g]),
      .o_y (w_col_out[g])
    );
  end

  // The last SUB cycle feeds the linear layer directly so the final result is ready one cycle early
  assign w_lin_in = (r_fsm == ST_SUB) ? w_sub_next : r_state;

  ascon_linear_layer u_lin (
    .i_state (w_lin_in),
    .o_state (w_lin_out)
  );

  // Round sequencer: CONST -> SUB x NCOL -> LIN, result published on entry to the final LIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= ST_IDLE;
      r_round     <= 4'd0;
      r_col       <= '0;
      r_state     <= '0;
      r_state_out <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_fsm)
        ST_CONST: begin
          r_state[135:128] <= r_state[135:128] ^ rc(r_round);
          r_col            <= '0;
          r_fsm            <= ST_SUB;
        end
        ST_SUB: begin
          r_state <= w_sub_next;
          r_col   <= r_col + 1'b1;
          if (r_col == CW'(NCOL - 1)) begin
            r_fsm <= ST_LIN;
            if (r_round == 4'd11) begin
              r_state_out <= w_lin_out;
              r_done      <= 1'b1;
              r_ready     <= 1'b1;
            end
          end
        end
        ST_LIN: begin
          r_done <= 1'b0;
          if (r_round != 4'd11) begin
            r_state <= w_lin_out;
            r_round <= r_round + 4'd1;
            r_fsm   <= ST_CONST;
          end else if (w_accept) begin
            r_state <= state_in;
            r_round <= 4'd12 - rounds;
            r_fsm   <= ST_CONST;
            r_ready <= 1'b0;
          end else begin
            r_fsm  <= ST_IDLE;
            r_busy <= 1'b0;
          end
        end
        default: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= state_in;
            r_round <= 4'd12 - rounds;
            r_fsm   <= ST_CONST;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
      endcase
    end
  end

`else

  state_t     w_rin;
  state_t     w_cst;
  state_t     w_sub;
  state_t     w_rout;
  logic [3:0] w_rr;

  // Round input: the accepting edge already runs the first round on state_in
  always_comb begin
    w_rin            = w_accept ? state_in : r_state;
    w_rr             = w_accept ? (4'd12 - rounds) : r_round;
    w_cst            = w_rin;
    w_cst[135:128]   = w_rin[135:128] ^ rc(w_rr);
  end

  for (genvar j = 0; j < 64; j++) begin : g_sbox
    logic [4:0] w_y;
    ascon_sbox u_sbox (
      .i_x ({w_cst[256+j], w_cst[192+j], w_cst[128+j], w_cst[64+j], w_cst[j]}),
      .o_y (w_y)
    );
    assign w_sub[256+j] = w_y[4];
    assign w_sub[192+j] = w_y[3];
    assign w_sub[128+j] = w_y[2];
    assign w_sub[64+j]  = w_y[1];
    assign w_sub[j]     = w_y[0];
  end

  ascon_linear_layer u_lin (
    .i_state (w_sub),
    .o_state (w_rout)
  );

  // One full round per cycle; ST_CONST stands for "round in progress" in this mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= ST_IDLE;
      r_round     <= 4'd0;
      r_state     <= '0;
      r_state_out <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_accept || (r_fsm == ST_CONST)) begin
      r_state <= w_rout;
      r_busy  <= 1'b1;
      if (w_rr == 4'd11) begin
        r_state_out <= w_rout;
        r_done      <= 1'b1;
        r_ready     <= 1'b1;
        r_fsm       <= ST_IDLE;
      end else begin
        r_round <= w_rr + 4'd1;
        r_done  <= 1'b0;
        r_ready <= 1'b0;
        r_fsm   <= ST_CONST;
      end
    end else begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end
  end

`endif

endmodule

// File: doc/ascon_permutation.md
# ascon_permutation

Iterative ASCON permutation engine that wraps the 5-bit S-box stage and runs 1–12 rounds over the 320-bit state. Each round applies three steps in order: round-constant addition (upstream of the S-box), bit-sliced substitution, and linear diffusion (downstream of the S-box). The block sits between the AEAD/hash mode controller and the S-box, and talks to the controller with a start/done handshake.

## Interface
- SLICE, default 8: S-box columns substituted per cycle in serial mode; must divide 64; ignored in parallel mode.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a permutation; sampled only while ready=1.
- rounds  input  4  round count a; valid range 1..12; sampled together with start.
- state_in  input  320  {x0,x1,x2,x3,x4}; x0 = [319:256], x4 = [63:0].
- ready  output  1  high in IDLE; start is accepted only while ready=1.
- busy  output  1  permutation in progress.
- done  output  1  one-cycle pulse when state_out is updated.
- state_out  output  320  result, in the same word order as state_in; holds its value until the next done.

## Operation
- FSM states: IDLE, CONST, SUB, LIN. Reset state is IDLE.
- Accept condition: start=1, ready=1 and 1≤rounds≤12. The block latches state_in, loads the round index r=12−rounds, and moves to CONST. If start=1 with rounds=0 or rounds>12, the request is ignored: no state change, no done.
- CONST: x2[7:0] ^= {4'hF−r[3:0], r[3:0]}. The constants are 0xF0 for r=0 and 0x4B for r=11.
- SUB: for each column j, form c = {x0[j],x1[j],x2[j],x3[j],x4[j]} with x0 as the MSB, and replace it with S(c).
  - S-box table: 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17.
- LIN: xi ^= ror(xi,a) ^ ror(xi,b), with (a,b) as follows:
  - x0: (19,28)
  - x1: (61,39)
  - x2: (1,6)
  - x3: (10,17)
  - x4: (7,41)
- After LIN: if r=11, write state_out, pulse done and go to IDLE. Otherwise increment r and go back to CONST.
- start while busy is ignored. rounds and state_in are don't-care after acceptance.
- rst at any time, including mid-permutation, aborts the operation and forces the reset values.
- Reset values: ready=1, busy=0, done=0, state_out=0, r=0, working state=0.

## Timing
- Parallel mode (macro undefined): CONST, SUB and LIN are merged into one cycle per round.
  - Start accepted at edge k: busy=1 during cycles k+1..k+rounds.
  - done=1 and state_out valid in cycle k+rounds; ready returns to 1 in that same cycle.
- Serial mode: each round takes 1 CONST + 64/SLICE SUB + 1 LIN cycles, i.e. 10 cycles/round with SLICE=8.
  - Latency = rounds×10 cycles; done is asserted in the final LIN cycle.
- Back-to-back: a start accepted in the done cycle begins the next permutation on the following edge, with no bubble.
- done and ready are registered outputs. state_out changes only on the cycle done rises.

## Configuration
- ASCON_SERIAL_SBOX_EN
  - Defined: SLICE S-box instances, with a column counter in SUB stepping through columns [SLICE·n +: SLICE] for n = 0..64/SLICE−1. The counter resets to 0 on entering SUB. This is the small-area variant.
  - Undefined: 64 S-box instances and a one-round-per-cycle datapath; CONST, SUB and LIN are not visited as separate states.
- Results are bit-identical in both modes; only latency differs.

## Structure
- Package ascon_pkg holds:
  - the 320-bit state and 64-bit word typedefs;
  - the FSM state enum;
  - the rotation-amount constants;
  - the round-constant function rc(r);
  - the SLICE default.
- One sub-module, ascon_linear_layer: combinational, 320 bits in and 320 bits out, implementing the five rotate-XOR equations.
- The S-box is instantiated from the existing 5-bit S-box block, with the column bit order mapped as given in Operation.

## Test plan
- Reset mid-run: assert rst after 3 rounds of a 12-round run -> ready=1, busy=0, done=0, state_out=0 immediately. A fresh start afterwards gives the correct result.
- Single round, zero state, rounds=1 -> S-box output is x0=x1=x3=0x4B, x2=0xFFFFFFFFFFFFFFB4, x4=0. After LIN, state_out x4=0 and the other words match the bit-true model. done arrives in cycle k+1 (parallel) or k+10 (serial).
- Random 320-bit states with rounds=12, 8 and 6 -> state_out matches the software model in both macro settings. Latency is exactly rounds, or rounds×10 in serial mode.
- start with rounds=0, then rounds=13 -> ready stays 1, busy stays 0, no done, state_out unchanged.
- start pulsed while busy, with a different state_in -> ignored; the result corresponds to the originally accepted state only.
- Back-to-back: a new start in the done cycle -> second done after exactly rounds (or rounds×10) further cycles, with no idle cycle between the two runs.
